// File: rtl/video_fifo_packer_if.sv
// video_fifo_packer_if: pixel stream, control, FIFO write and status bundle for the packer.
interface video_fifo_packer_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int PIXEL_WIDTH       = 8,
    parameter int FRAME_COUNT_WIDTH = 16,
    parameter int COUNT_WIDTH       = 20
);
    logic [PIXEL_WIDTH-1:0]       iPixel;
    logic                         iPixelValid;
    logic                         iFrameStart;
    logic                         iFrameEnd;
    logic                         iArm;
    logic                         iClearStatus;
    logic                         iFull;
    logic [DATA_WIDTH-1:0]        oData;
    logic                         oWriteEn;
    logic                         oBusy;
    logic [COUNT_WIDTH-1:0]       oWordCount;
    logic [COUNT_WIDTH-1:0]       oDropCount;
    logic                         oOverflow;
    logic [FRAME_COUNT_WIDTH-1:0] oFrameCount;

    modport master (
        input  iPixel, iPixelValid, iFrameStart, iFrameEnd, iArm, iClearStatus, iFull,
        output oData, oWriteEn, oBusy, oWordCount, oDropCount, oOverflow, oFrameCount
    );
    modport slave (
        output iPixel, iPixelValid, iFrameStart, iFrameEnd, iArm, iClearStatus, iFull,
        input  oData, oWriteEn, oBusy, oWordCount, oDropCount, oOverflow, oFrameCount
    );
endinterface

// File: rtl/video_fifo_packer.sv
// video_fifo_packer: captures one armed frame, packing pixels MSB-first into FIFO words.
// Define VIDEO_PACKER_HEADER_EN to emit a {8'hA5, 0, frame count} header word per frame.
module video_fifo_packer #(
    parameter int DATA_WIDTH        = 32,
    parameter int PIXEL_WIDTH       = 8,
    parameter int FRAME_COUNT_WIDTH = 16,
    parameter int COUNT_WIDTH       = 20
) (
    input logic                 iClk,
    input logic                 iResetN,
    video_fifo_packer_if.master bus
);
    localparam int PPW = DATA_WIDTH / PIXEL_WIDTH;
    localparam int SLOT_W = PPW > 1 ? $clog2(PPW) : 1;
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(PPW - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;

    state_t                       r_state, w_next;
    logic [SLOT_W-1:0]            r_slot;
    logic [DATA_WIDTH-1:0]        r_shift, r_data, w_word, w_emit_data;
    logic                         r_we, r_overflow, w_emit, w_load, w_write, w_drop;
    logic [COUNT_WIDTH-1:0]       r_word_count, r_drop_count;
    logic [FRAME_COUNT_WIDTH-1:0] r_frame_count;

    // Unfilled slots of r_shift are always zero, so a flushed partial word is already padded.
    assign w_word  = r_shift | (DATA_WIDTH'(bus.iPixel) << ((PPW - 1 - int'(r_slot)) * PIXEL_WIDTH));
    assign w_write = w_emit && !bus.iFull;
    assign w_drop  = w_emit && bus.iFull;

`ifdef VIDEO_PACKER_HEADER_EN
    logic [DATA_WIDTH-1:0] w_hdr;
    assign w_hdr = (DATA_WIDTH'(8'hA5) << (DATA_WIDTH - 8)) | DATA_WIDTH'(r_frame_count);
`endif

    always_ff @(posedge iClk) begin
        if (!iResetN) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_emit      = 1'b0;
        w_emit_data = w_word;
        w_load      = 1'b0;
        case (r_state)
            IDLE: if (bus.iArm) w_next = ARMED;
            ARMED: if (bus.iFrameStart) begin
                w_next = CAPTURE;
`ifdef VIDEO_PACKER_HEADER_EN
                w_emit      = 1'b1;
                w_emit_data = w_hdr;
`endif
            end
            CAPTURE: begin
                w_load = bus.iPixelValid;
                w_emit = bus.iPixelValid && r_slot == LAST;
                if (bus.iFrameEnd) w_next = FLUSH;
            end
            FLUSH: begin
                w_emit      = r_slot != '0;
                w_emit_data = r_shift;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iResetN) begin
            r_slot        <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_we          <= 1'b0;
            r_word_count  <= '0;
            r_drop_count  <= '0;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_data <= w_emit_data;
                if (!(&r_word_count)) r_word_count <= r_word_count + COUNT_WIDTH'(1);
            end
            if (bus.iClearStatus) begin
                r_drop_count <= '0;
                r_overflow   <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (!(&r_drop_count)) r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
            end
            if (r_state == IDLE && bus.iArm) begin
                r_word_count <= '0;
                r_slot       <= '0;
                r_shift      <= '0;
            end
            if (w_load) begin
                r_slot  <= r_slot == LAST ? '0 : r_slot + SLOT_W'(1);
                r_shift <= r_slot == LAST ? '0 : w_word;
            end
            if (r_state == FLUSH) begin
                r_frame_count <= r_frame_count + FRAME_COUNT_WIDTH'(1);
                r_slot        <= '0;
                r_shift       <= '0;
            end
        end
    end

    assign bus.oData       = r_data;
    assign bus.oWriteEn    = r_we;
    assign bus.oBusy       = r_state != IDLE;
    assign bus.oWordCount  = r_word_count;
    assign bus.oDropCount  = r_drop_count;
    assign bus.oOverflow   = r_overflow;
    assign bus.oFrameCount = r_frame_count;
endmodule
